// File: rtl/e_cpu_io_bridge.sv
// CPU-side end of the east-edge CPU I/O tile link.
// Frames a request onto the operand lanes and collects byte result beats.
module e_cpu_io_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FUNCT_W        = 3
) (
    input  logic               CLK,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FUNCT_W-1:0] req_funct,
    input  logic [31:0]        req_op_a,
    input  logic [31:0]        req_op_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic               rsp_timeout,
    output logic [3:0]         OPA_O,
    output logic [3:0]         OPB_O,
    input  logic [3:0]         RES0_I,
    input  logic [3:0]         RES1_I,
    input  logic [3:0]         RES2_I
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  beat_q, beat_d;
    logic [1:0]  byte_q, byte_d;
    logic [15:0] tmo_q, tmo_d;
    logic [23:0] res_q, res_d;
    logic [3:0]  opa_q, opa_d;
    logic [3:0]  opb_q, opb_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_tmo_q, rsp_tmo_d;

    logic unused_res2;
    assign unused_res2 = &{1'b0, RES2_I[3:1]};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        beat_d      = beat_q;
        byte_d      = byte_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        opa_d       = 4'h0;
        opb_d       = 4'h0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tmo_d   = rsp_tmo_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d     = req_op_a;
                    b_d     = req_op_b;
                    opa_d   = {1'b1, req_funct[2:0]};
                    state_d = HDR;
                end
            end
            HDR: begin
                opa_d   = a_q[3:0];
                opb_d   = b_q[3:0];
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                beat_d  = 3'd0;
                state_d = SEND;
            end
            SEND: begin
                if (beat_q == 3'd7) begin
                    tmo_d   = 16'd0;
                    byte_d  = 2'd0;
                    state_d = WAIT;
                end else begin
                    opa_d  = a_q[3:0];
                    opb_d  = b_q[3:0];
                    a_d    = a_q >> 4;
                    b_d    = b_q >> 4;
                    beat_d = beat_q + 3'd1;
                end
            end
            WAIT: begin
                // A final beat landing on the timeout cycle still completes.
                if (RES2_I[0] && byte_q == 2'd3) begin
                    rsp_data_d  = {RES1_I, RES0_I, res_q};
                    rsp_tmo_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    if (RES2_I[0]) begin
                        res_d[{byte_q, 3'b000} +: 8] = {RES1_I, RES0_I};
                        byte_d = byte_q + 2'd1;
                    end
                    if (tmo_q == TMO_LAST) begin
                        rsp_data_d  = 32'h0;
                        rsp_tmo_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            beat_q      <= 3'd0;
            byte_q      <= 2'd0;
            tmo_q       <= 16'd0;
            res_q       <= 24'h0;
            opa_q       <= 4'h0;
            opb_q       <= 4'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            beat_q      <= beat_d;
            byte_q      <= byte_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_tmo_q;
    assign OPA_O       = opa_q;
    assign OPB_O       = opb_q;

endmodule
